// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - Shared states, default sizes and saturation helper for the period meter.
package period_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} pmState_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic logic [31:0] satMax(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// rtl/period_meter_edge_sync.sv - Synchronizer chain plus edge register producing registered rise/fall strobes.
module edge_sync
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic pulseIn,
  output logic sync,
  output logic riseStb,
  output logic fallStb
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   syncPrev;

  // Strobes are registered alongside syncPrev so that sync, riseStb and fallStb stay cycle-aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain    <= '0;
      syncPrev <= 1'b0;
      riseStb  <= 1'b0;
      fallStb  <= 1'b0;
    end else begin
      chain    <= {chain[SYNC_STAGES-2:0], pulseIn};
      syncPrev <= chain[SYNC_STAGES-1];
      riseStb  <= chain[SYNC_STAGES-1] & ~syncPrev;
      fallStb  <= ~chain[SYNC_STAGES-1] & syncPrev;
    end
  end

  assign sync = syncPrev;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - Measures the period of a pulse train and offers it on a valid/ready port.
// Define PERIOD_METER_DUTY_EN to also measure the high time of each period on highOut.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulseIn,
  output logic [CNT_W-1:0] periodOut,
  output logic [CNT_W-1:0] highOut,
  output logic             periodOvf,
  output logic             periodValid,
  input  logic             periodReady,
  output logic             dropped,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(satMax(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pmState_t         state;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             sync;
  logic             riseStb;
  logic             fallStb;
  logic             complete;
  logic [CNT_W-1:0] highNext;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uEdgeSync (
    .clock   (clock),
    .reset   (reset),
    .pulseIn (pulseIn),
    .sync    (sync),
    .riseStb (riseStb),
    .fallStb (fallStb)
  );

  assign complete = (state == MEASURE) && enable && riseStb;

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] highHold;

  // highHold is cleared at each rise so a period without a fall reports zero high time.
  always_ff @(posedge clock) begin
    if (reset || state == IDLE) begin
      hcnt     <= '0;
      highHold <= '0;
    end else if (riseStb) begin
      hcnt     <= CNT_ONE;
      highHold <= '0;
    end else begin
      if (sync && hcnt != CNT_MAX) hcnt <= hcnt + CNT_ONE;
      if (fallStb) highHold <= hcnt;
    end
  end

  assign highNext = highHold;
`else
  logic unusedDuty;
  assign unusedDuty = sync ^ fallStb;
  assign highNext   = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ovf         <= 1'b0;
      periodOut   <= '0;
      highOut     <= '0;
      periodOvf   <= 1'b0;
      periodValid <= 1'b0;
      dropped     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= enable;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (riseStb) begin
              state <= MEASURE;
              cnt   <= CNT_ONE;
              ovf   <= 1'b0;
            end
          end
          MEASURE: begin
            if (riseStb) begin
              cnt <= CNT_ONE;
              ovf <= 1'b0;
            end else if (cnt >= CNT_MAX - CNT_ONE) begin
              cnt <= CNT_MAX;
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A held, unaccepted result wins over a newer one; the newer one is counted as dropped.
      if (complete && (!periodValid || periodReady)) begin
        periodOut   <= cnt;
        periodOvf   <= ovf;
        highOut     <= highNext;
        periodValid <= 1'b1;
      end else if (complete) begin
        dropped <= 1'b1;
      end else if (periodReady) begin
        periodValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - Randomized and directed self-checking bench for period_meter (16-bit and 4-bit instances).
module tb_period_meter;

  localparam int SYNC = 2;
  localparam int LAG  = SYNC + 1;
  localparam int WB   = 16;
  localparam int WS   = 4;
  localparam int MAXB = 65535;
  localparam int MAXS = 15;
`ifdef PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, enable, pulseIn, periodReady;
  logic [WB-1:0] bPeriod, bHigh;
  logic [WS-1:0] sPeriod, sHigh;
  logic bOvf, bValid, bDropped, bBusy;
  logic sOvf, sValid, sDropped, sBusy;

  always #5 clock = ~clock;

  period_meter #(.CNT_W(WB), .SYNC_STAGES(SYNC)) dutBig (
    .clock(clock), .reset(reset), .enable(enable), .pulseIn(pulseIn),
    .periodOut(bPeriod), .highOut(bHigh), .periodOvf(bOvf), .periodValid(bValid),
    .periodReady(periodReady), .dropped(bDropped), .busy(bBusy)
  );

  period_meter #(.CNT_W(WS), .SYNC_STAGES(SYNC)) dutSmall (
    .clock(clock), .reset(reset), .enable(enable), .pulseIn(pulseIn),
    .periodOut(sPeriod), .highOut(sHigh), .periodOvf(sOvf), .periodValid(sValid),
    .periodReady(periodReady), .dropped(sDropped), .busy(sBusy)
  );

  int tests = 0;
  int fails = 0;
  bit cmpOn = 1'b0;
  bit rndReady = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference model: tracks rise/fall times of the sampled input and derives results from timestamps.
  int cyc = 0;
  bit hist[$] = '{0, 0, 0, 0, 0, 0};
  bit prevEn = 0, haveRise = 0, fallSeen = 0;
  int lastRise = 0, fallT = 0;
  bit eValid = 0, eDropped = 0, eBusy = 0, eOvfB = 0, eOvfS = 0;
  int ePerB = 0, ePerS = 0, eHighB = 0, eHighS = 0;

  always @(posedge clock) begin
    bit rise, fall, fin;
    int per, hi;
    cyc++;
    if (reset) begin
      foreach (hist[k]) hist[k] = 0;
      prevEn = 0; haveRise = 0; fallSeen = 0;
      eValid = 0; eDropped = 0; eBusy = 0; eOvfB = 0; eOvfS = 0;
      ePerB = 0; ePerS = 0; eHighB = 0; eHighS = 0;
    end else begin
      hist.push_front(pulseIn);
      void'(hist.pop_back());
      rise = hist[LAG] && !hist[LAG+1];
      fall = !hist[LAG] && hist[LAG+1];
      fin = 0; per = 0; hi = 0;
      if (!(prevEn && enable)) begin
        haveRise = 0;
      end else begin
        if (fall && haveRise) begin
          fallSeen = 1;
          fallT = cyc;
        end
        if (rise) begin
          if (haveRise) begin
            fin = 1;
            per = cyc - lastRise;
            hi  = fallSeen ? fallT - lastRise : 0;
          end
          haveRise = 1;
          lastRise = cyc;
          fallSeen = 0;
        end
      end
      if (fin && (!eValid || periodReady)) begin
        eValid = 1;
        ePerB = sat(per, MAXB); eOvfB = (per >= MAXB);
        ePerS = sat(per, MAXS); eOvfS = (per >= MAXS);
        eHighB = DUTY ? sat(hi, MAXB) : 0;
        eHighS = DUTY ? sat(hi, MAXS) : 0;
      end else if (fin) begin
        eDropped = 1;
      end else if (periodReady) begin
        eValid = 0;
      end
      prevEn = enable;
      eBusy  = enable;
    end
  end

  always @(negedge clock) begin
    if (cmpOn) begin
      check("big_valid", bValid, eValid);
      check("big_period", bPeriod, ePerB);
      check("big_ovf", bOvf, eOvfB);
      check("big_high", bHigh, eHighB);
      check("big_dropped", bDropped, eDropped);
      check("big_busy", bBusy, eBusy);
      check("small_valid", sValid, eValid);
      check("small_period", sPeriod, ePerS);
      check("small_ovf", sOvf, eOvfS);
      check("small_high", sHigh, eHighS);
      check("small_dropped", sDropped, eDropped);
    end
  end

  int xfers = 0;
  int lastB = 0, lastS = 0, lastHighB = 0;
  bit lastOvfB = 0, lastOvfS = 0;

  always @(negedge clock) begin
    if (!reset && bValid && periodReady) begin
      xfers++;
      lastB = bPeriod; lastOvfB = bOvf; lastHighB = bHigh;
      lastS = sPeriod; lastOvfS = sOvf;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
    if (rndReady) periodReady = 1'($urandom_range(0, 1));
  endtask

  task automatic pulses(input int hi, input int lo, input int n);
    repeat (n) begin
      pulseIn = 1'b1;
      repeat (hi) tick();
      pulseIn = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    finishRun();
  end

  initial begin
    int x;
    int hi, lo;
    reset = 1'b1; enable = 1'b0; pulseIn = 1'b0; periodReady = 1'b1;
    tick(); tick();
    cmpOn = 1'b1;
    @(negedge clock);
    check("rst_valid", bValid, 0);
    check("rst_busy", bBusy, 0);
    check("rst_period", bPeriod, 0);
    reset = 1'b0;

    // 1 high / 5 low, then latency of the third rise
    enable = 1'b1;
    tick();
    pulses(1, 5, 2);
    pulseIn = 1'b1; tick(); pulseIn = 1'b0; tick(); tick();
    @(negedge clock);
    check("lat_early", bValid, 0);
    tick();
    @(negedge clock);
    check("lat_valid", bValid, 1);
    check("lat_period", bPeriod, 6);
    check("lat_ovf", bOvf, 0);
    tick(); tick();

    // saturation on the 4-bit instance
    pulses(1, 19, 2);
    pulses(1, 5, 1);
    check("sat_small_period", lastS, 15);
    check("sat_small_ovf", lastOvfS, 1);
    check("sat_big_period", lastB, 20);
    check("sat_big_ovf", lastOvfB, 0);
    pulses(1, 5, 1);
    check("unsat_small_period", lastS, 6);
    check("unsat_small_ovf", lastOvfS, 0);

    // enable dropped three cycles into a period
    pulseIn = 1'b1; tick(); pulseIn = 1'b0;
    repeat (6) tick();
    enable = 1'b0;
    x = xfers;
    repeat (2) tick();
    @(negedge clock);
    check("dis_busy", bBusy, 0);
    pulses(1, 5, 2);
    check("dis_no_result", xfers, x);
    check("dis_dropped", bDropped, 0);
    enable = 1'b1;
    pulses(1, 5, 1);
    check("reen_arm_only", xfers, x);
    pulses(1, 5, 1);
    check("reen_result", xfers, x + 1);
    check("reen_period", lastB, 6);

    // backpressure and drop
    periodReady = 1'b0;
    pulses(1, 5, 1);
    @(negedge clock);
    check("hold_valid", bValid, 1);
    check("hold_period", bPeriod, 6);
    check("hold_dropped", bDropped, 0);
    pulses(1, 5, 1);
    @(negedge clock);
    check("drop_set", bDropped, 1);
    check("drop_period", bPeriod, 6);
    periodReady = 1'b1;
    tick();
    @(negedge clock);
    check("drop_xfer_clear", bValid, 0);
    x = xfers;
    pulses(1, 5, 2);
    check("drop_resume", xfers, x + 2);
    check("drop_resume_period", lastB, 6);

    // reset in the middle of a measurement
    pulseIn = 1'b1; tick(); pulseIn = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("mid_rst_busy", bBusy, 0);
    check("mid_rst_valid", bValid, 0);
    check("mid_rst_dropped", bDropped, 0);
    check("mid_rst_period", bPeriod, 0);
    check("mid_rst_small_period", sPeriod, 0);
    reset = 1'b0;
    x = xfers;
    pulses(1, 5, 1);
    check("post_rst_arm_only", xfers, x);
    check("post_rst_busy", bBusy, 1);
    pulses(1, 5, 1);
    check("post_rst_result", xfers, x + 1);

    // high time
    pulses(2, 4, 3);
    check("duty_period", lastB, 6);
    check("duty_high", lastHighB, DUTY ? 2 : 0);

    // randomized traffic
    rndReady = 1'b1;
    repeat (250) begin
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(14, 24);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      pulses(hi, lo, 1);
    end
    rndReady = 1'b0;
    periodReady = 1'b1;
    repeat (10) tick();
    finishRun();
  end

endmodule
